gumnut_int_ctrl: RTL and testbench

Interrupt sequencer for the Gumnut core; it is the producer side of the flag register's interrupt-restore path (`iwe`/`intc`/`intz`). On an enabled interrupt at an instruction boundary it saves the return PC and the C/Z flags, then redirects fetch to the vector and acknowledges the source. On `reti` it drives the saved flags back into the flag register and the saved PC back to the PC. It sits between the control unit, the flag register and the external interrupt line.

---
 rtl/gumnut_pkg.sv | 14 +
 rtl/gumnut_int_shadow.sv | 25 ++
 rtl/gumnut_int_ctrl.sv | 109 ++++++++++
 tb/tb_gumnut_int_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_pkg.sv
// Shared types and defaults for the Gumnut interrupt sequencer.
package gumnut_pkg;

  localparam int unsigned PC_W = 12;
  localparam logic [PC_W-1:0] INT_VECTOR = 12'h001;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StHandler,
    StReturn
  } int_state_t;

endpackage

// File: rtl/gumnut_int_shadow.sv
// Capture register for the interrupted context (return PC plus C/Z flags).
module gumnut_int_shadow #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (cen && load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gumnut_int_ctrl.sv
// Interrupt sequencer: saves PC/flags on entry, redirects to the vector, and
// drives the saved context back to the PC and flag register on reti.
module gumnut_int_ctrl #(
  parameter int unsigned          PC_W       = gumnut_pkg::PC_W,
  parameter logic [PC_W-1:0]      INT_VECTOR = gumnut_pkg::INT_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            int_req,
  input  logic            boundary,
  input  logic [PC_W-1:0] pc_i,
  input  logic            c_i,
  input  logic            z_i,
  input  logic            enai,
  input  logic            disi,
  input  logic            reti,
  output logic            take_int_o,
  output logic [PC_W-1:0] vector_o,
  output logic            int_ack_o,
  output logic            pc_restore_o,
  output logic [PC_W-1:0] ret_pc_o,
  output logic            iwe_o,
  output logic            intc_o,
  output logic            intz_o,
  output logic            int_en_o,
  output logic            in_service_o
);

  import gumnut_pkg::*;

  int_state_t state_q, state_d;
  logic       int_en_q, int_en_d;
  logic       capture;
  logic [PC_W+1:0] shadow_q;

  always_comb begin
    state_d  = state_q;
    int_en_d = int_en_q;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (disi) begin
          int_en_d = 1'b0;
        end else if (enai) begin
          int_en_d = 1'b1;
        end
        // Decision uses the registered enable, so same-cycle enai/disi do not affect it.
        if (int_en_q && int_req && boundary) begin
          capture  = 1'b1;
          int_en_d = 1'b0;
          state_d  = StEntry;
        end
      end
      StEntry: begin
        int_en_d = 1'b0;
        state_d  = StHandler;
      end
      StHandler: begin
        int_en_d = 1'b0;
        if (reti) begin
          int_en_d = 1'b1;
          state_d  = StReturn;
        end
      end
      StReturn: begin
        int_en_d = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        int_en_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      int_en_q <= 1'b0;
    end else if (cen) begin
      state_q  <= state_d;
      int_en_q <= int_en_d;
    end
  end

  gumnut_int_shadow #(
    .W (PC_W + 2)
  ) u_shadow (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .load (capture),
    .d    ({pc_i, c_i, z_i}),
    .q    (shadow_q)
  );

  assign take_int_o   = (state_q == StEntry);
  assign int_ack_o    = (state_q == StEntry);
  assign in_service_o = (state_q == StHandler);
  assign iwe_o        = (state_q == StReturn);
  assign pc_restore_o = (state_q == StReturn);
  assign vector_o     = INT_VECTOR;
  assign ret_pc_o     = shadow_q[PC_W+1:2];
  assign intc_o       = shadow_q[1];
  assign intz_o       = shadow_q[0];
  assign int_en_o     = int_en_q;

endmodule

// File: tb/tb_gumnut_int_ctrl.sv
// Scoreboard bench for gumnut_int_ctrl: stimulus queues expected strobe cycles,
// a negedge monitor pops and compares whenever a strobe is presented.
module tb_gumnut_int_ctrl;

  localparam int unsigned PC_W = 12;

  logic            clk = 1'b0;
  logic            rst, cen, int_req, boundary, c_i, z_i, enai, disi, reti;
  logic [PC_W-1:0] pc_i;
  logic            take_int_o, int_ack_o, pc_restore_o, iwe_o, intc_o, intz_o;
  logic            int_en_o, in_service_o;
  logic [PC_W-1:0] vector_o, ret_pc_o;

  int n_cmp = 0;
  int n_err = 0;

  // {take, ack, iwe, restore, intc, intz, int_en, in_service, ret_pc}
  typedef struct {
    string       name;
    logic [19:0] vec;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  gumnut_int_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cen          (cen),
    .int_req      (int_req),
    .boundary     (boundary),
    .pc_i         (pc_i),
    .c_i          (c_i),
    .z_i          (z_i),
    .enai         (enai),
    .disi         (disi),
    .reti         (reti),
    .take_int_o   (take_int_o),
    .vector_o     (vector_o),
    .int_ack_o    (int_ack_o),
    .pc_restore_o (pc_restore_o),
    .ret_pc_o     (ret_pc_o),
    .iwe_o        (iwe_o),
    .intc_o       (intc_o),
    .intz_o       (intz_o),
    .int_en_o     (int_en_o),
    .in_service_o (in_service_o)
  );

  function automatic logic [19:0] pack_obs();
    return {take_int_o, int_ack_o, iwe_o, pc_restore_o, intc_o, intz_o,
            int_en_o, in_service_o, ret_pc_o};
  endfunction

  function automatic logic [19:0] mk(input logic take, input logic iwe, input logic intc,
                                     input logic intz, input logic en,
                                     input logic [PC_W-1:0] pc);
    return {take, take, iwe, iwe, intc, intz, en, 1'b0, pc};
  endfunction

  // Monitor: every strobe cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (take_int_o || int_ack_o || iwe_o || pc_restore_o) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got %h, required no strobe", pack_obs());
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (pack_obs() !== e.vec || vector_o !== 12'h001) begin
          n_err++;
          $display("FAIL %s: got %h vec %h, required %h vec 001", e.name, pack_obs(),
                   vector_o, e.vec);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [19:0] v);
    exp_t e;
    e.name = name;
    e.vec  = v;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; int_req = 1'b1; boundary = 1'b1; pc_i = '0;
    c_i = 1'b0; z_i = 1'b0; enai = 1'b0; disi = 1'b0; reti = 1'b0;

    // Reset with request active
    tick(); tick();
    check("rst_outputs", 32'(pack_obs()), 32'h0);
    check("rst_vector", 32'(vector_o), 32'h001);
    rst = 1'b0;
    tick(); tick();
    check("no_take_when_disabled", {31'b0, take_int_o}, 32'd0);

    // enai with a qualifying boundary: no entry yet
    enai = 1'b1; pc_i = 12'h0A5; c_i = 1'b1; z_i = 1'b0;
    tick();
    enai = 1'b0;
    check("enai_same_cycle_no_take", {31'b0, take_int_o}, 32'd0);
    check("enai_sets_en", {31'b0, int_en_o}, 32'd1);

    // Entry; a same-cycle disi must not block it
    disi = 1'b1;
    push("entry_0a5", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0A5));
    tick();
    disi = 1'b0; boundary = 1'b0; int_req = 1'b0;
    check("entry_take", {31'b0, take_int_o}, 32'd1);
    tick();
    check("handler_in_service", {31'b0, in_service_o}, 32'd1);
    enai = 1'b1; int_req = 1'b1; boundary = 1'b1;
    tick();
    enai = 1'b0; int_req = 1'b0; boundary = 1'b0;
    check("handler_en_held", {31'b0, int_en_o}, 32'd0);
    check("handler_no_nesting", {31'b0, in_service_o}, 32'd1);

    // Return
    reti = 1'b1;
    push("return_0a5", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0A5));
    tick();
    reti = 1'b0;
    check("return_iwe", {31'b0, iwe_o}, 32'd1);
    tick();
    check("idle_after_return", {29'b0, iwe_o, in_service_o, int_en_o}, 32'd1);

    // enai and disi together: disi wins
    enai = 1'b1; disi = 1'b1;
    tick();
    enai = 1'b0; disi = 1'b0;
    check("disi_wins", {31'b0, int_en_o}, 32'd0);

    // Entry held by cen=0 for three cycles
    enai = 1'b1;
    tick();
    enai = 1'b0; int_req = 1'b1; boundary = 1'b1; pc_i = 12'h3C2; c_i = 1'b0; z_i = 1'b1;
    for (int i = 0; i < 4; i++) push("entry_cen_hold", mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h3C2));
    tick();
    int_req = 1'b0; boundary = 1'b0; cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cen_hold_take", {31'b0, take_int_o}, 32'd1);
    end
    cen = 1'b1;
    tick();
    check("cen_release_advance", {30'b0, take_int_o, in_service_o}, 32'd1);

    // Reset mid-handler, then a stray reti
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_handler_state", {30'b0, in_service_o, int_en_o}, 32'd0);
    check("rst_shadow", 32'({ret_pc_o, intc_o, intz_o}), 32'd0);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check("stray_reti", {30'b0, iwe_o, pc_restore_o}, 32'd0);

    // Back-to-back interrupts
    enai = 1'b1;
    tick();
    enai = 1'b0; int_req = 1'b1; boundary = 1'b1; pc_i = 12'h123; c_i = 1'b1; z_i = 1'b1;
    push("entry_123", mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123));
    tick();
    int_req = 1'b0; boundary = 1'b0;
    tick();
    reti = 1'b1;
    push("return_123", mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h123));
    tick();
    reti = 1'b0; int_req = 1'b1; boundary = 1'b1; pc_i = 12'h456; c_i = 1'b0; z_i = 1'b0;
    push("entry_456", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456));
    tick();
    tick();
    int_req = 1'b0; boundary = 1'b0;
    check("back_to_back_take", {31'b0, take_int_o}, 32'd1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
